// File: rtl/wb_pkg.sv
// Shared widths, lane numbering and port payload type for the writeback arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int STATUS_W = 2;

  localparam int NUM_WB_LANES = 4;
  localparam int NUM_WB_PORTS = 2;

  localparam int LANE_ARITH_A = 0;
  localparam int LANE_ARITH_B = 1;
  localparam int LANE_STORE_A = 2;
  localparam int LANE_STORE_B = 3;

  typedef logic [1:0] lane_idx_t;

  // One register-file write port payload.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   dat;
    logic [STATUS_W-1:0] status;
  } wb_port_t;

  // One-hot lane mask to lane index; zero mask maps to lane 0.
  function automatic lane_idx_t oh_to_idx(input logic [NUM_WB_LANES-1:0] oh);
    lane_idx_t idx;
    idx = '0;
    for (int n = 0; n < NUM_WB_LANES; n++) begin
      if (oh[n]) idx = lane_idx_t'(n);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Picks the first set bit of a 4-lane mask, scanning upward from a start pointer with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller gates the pick.
module rr_pick4
  import wb_pkg::*;
(
  input  logic [NUM_WB_LANES-1:0] req_mask,
  input  lane_idx_t               start_ptr,
  output logic [NUM_WB_LANES-1:0] pick_oh,
  output logic                    found
);

  // Rotating scan: start_ptr, start_ptr+1, ... modulo 4, first hit wins.
  always_comb begin
    lane_idx_t scan;
    pick_oh = '0;
    found   = 1'b0;
    scan    = start_ptr;
    for (int k = 0; k < NUM_WB_LANES; k++) begin
      scan = start_ptr + lane_idx_t'(k);
      if (!found && req_mask[scan]) begin
        pick_oh[scan] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_port_arbiter.sv
// Grants up to two of four writeback lanes per cycle onto register-file ports A/B, round-robin, no same-address pair.
// Latency: grant (req_ready_o) is combinational; the granted payload appears on the port one cycle later.
// Backpressure: stall_i or reset suppresses all grants; ungranted requesters hold valid and payload.
module writeback_port_arbiter
  import wb_pkg::*;
(
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [NUM_WB_LANES-1:0]       req_valid_i,
  output logic [NUM_WB_LANES-1:0]       req_ready_o,
  input  logic [NUM_WB_LANES*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_WB_LANES*DATA_W-1:0] req_data_i,
  input  logic [2*STATUS_W-1:0]         arith_status_i,
  input  logic                          stall_i,
  output logic                          enableA_o,
  output logic                          enableB_o,
  output logic [ADDR_W-1:0]             AddressA_o,
  output logic [ADDR_W-1:0]             AddressB_o,
  output logic [DATA_W-1:0]             DataA_o,
  output logic [DATA_W-1:0]             DataB_o,
  output logic [STATUS_W-1:0]           statusA_o,
  output logic [STATUS_W-1:0]           statusB_o
);

  lane_idx_t               rr_ptr;
  logic [STATUS_W-1:0]     last_status_a;
  logic [STATUS_W-1:0]     last_status_b;
  logic [ADDR_W-1:0]       lane_addr   [NUM_WB_LANES];
  logic [DATA_W-1:0]       lane_dat    [NUM_WB_LANES];
  logic [STATUS_W-1:0]     lane_status [NUM_WB_LANES];
  logic [NUM_WB_LANES-1:0] a_oh, b_oh, same_mask, b_mask, grant_oh;
  logic                    a_found, b_found, skip_found, conflict, gnt_en;
  lane_idx_t               a_idx, b_idx, skip_idx, rr_next;
  logic                    en_a_q, en_b_q;
  wb_port_t                port_a_q, port_b_q;

  // Unpack the per-lane address and data buses.
  always_comb begin
    for (int n = 0; n < NUM_WB_LANES; n++) begin
      lane_addr[n] = req_addr_i[n*ADDR_W +: ADDR_W];
      lane_dat[n]  = req_data_i[n*DATA_W +: DATA_W];
    end
  end

  // Port A: first valid lane from rr_ptr.
  rr_pick4 u_pick_a (
    .req_mask  (req_valid_i),
    .start_ptr (rr_ptr),
    .pick_oh   (a_oh),
    .found     (a_found)
  );

  assign a_idx = oh_to_idx(a_oh);

  // Lanes targeting port A's register cannot share the cycle with it.
  always_comb begin
    same_mask = '0;
    for (int n = 0; n < NUM_WB_LANES; n++) begin
      same_mask[n] = req_valid_i[n] && !a_oh[n] && (lane_addr[n] == lane_addr[a_idx]);
    end
  end

  assign b_mask = req_valid_i & ~a_oh & ~same_mask;

  // Port B: next non-conflicting valid lane; lanes before A are invalid, so rr_ptr works as start.
  rr_pick4 u_pick_b (
    .req_mask  (b_mask),
    .start_ptr (rr_ptr),
    .pick_oh   (b_oh),
    .found     (b_found)
  );

  assign b_idx = oh_to_idx(b_oh);

  // A skip only counts if the same-address lane sits ahead of port B in scan order (or B found nothing).
  always_comb begin
    lane_idx_t scan;
    skip_found = 1'b0;
    skip_idx   = rr_ptr;
    scan       = rr_ptr;
    for (int k = 0; k < NUM_WB_LANES; k++) begin
      scan = rr_ptr + lane_idx_t'(k);
      if (!skip_found && same_mask[scan]) begin
        skip_found = 1'b1;
        skip_idx   = scan;
      end
    end
    conflict = skip_found && (!b_found || ((skip_idx - rr_ptr) < (b_idx - rr_ptr)));
  end

  // Next pointer: revisit the first skipped lane, else move past the last grant.
  always_comb begin
    if (conflict)     rr_next = skip_idx;
    else if (b_found) rr_next = b_idx + 2'd1;
    else              rr_next = a_idx + 2'd1;
  end

  // Store lanes carry their side's latest arith status, forwarded when that arith lane wins this cycle.
  always_comb begin
    lane_status[LANE_ARITH_A] = arith_status_i[0 +: STATUS_W];
    lane_status[LANE_ARITH_B] = arith_status_i[STATUS_W +: STATUS_W];
    lane_status[LANE_STORE_A] = (a_oh[LANE_ARITH_A] || b_oh[LANE_ARITH_A]) ?
                                arith_status_i[0 +: STATUS_W] : last_status_a;
    lane_status[LANE_STORE_B] = (a_oh[LANE_ARITH_B] || b_oh[LANE_ARITH_B]) ?
                                arith_status_i[STATUS_W +: STATUS_W] : last_status_b;
  end

  assign gnt_en      = reset_ni && !stall_i;
  assign grant_oh    = (a_oh | b_oh) & {NUM_WB_LANES{gnt_en}};
  assign req_ready_o = grant_oh;

  // Register the granted payloads, pointer and per-side status history.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr        <= '0;
      last_status_a <= '0;
      last_status_b <= '0;
      en_a_q        <= 1'b0;
      en_b_q        <= 1'b0;
      port_a_q      <= '0;
      port_b_q      <= '0;
    end else begin
      en_a_q <= gnt_en && a_found;
      en_b_q <= gnt_en && b_found;
      if (gnt_en && a_found) begin
        port_a_q <= '{addr: lane_addr[a_idx], dat: lane_dat[a_idx], status: lane_status[a_idx]};
        rr_ptr   <= rr_next;
      end
      if (gnt_en && b_found) begin
        port_b_q <= '{addr: lane_addr[b_idx], dat: lane_dat[b_idx], status: lane_status[b_idx]};
      end
      if (grant_oh[LANE_ARITH_A]) last_status_a <= lane_status[LANE_ARITH_A];
      if (grant_oh[LANE_ARITH_B]) last_status_b <= lane_status[LANE_ARITH_B];
    end
  end

  assign enableA_o  = en_a_q;
  assign enableB_o  = en_b_q;
  assign AddressA_o = port_a_q.addr;
  assign AddressB_o = port_b_q.addr;
  assign DataA_o    = port_a_q.dat;
  assign DataB_o    = port_b_q.dat;
  assign statusA_o  = port_a_q.status;
  assign statusB_o  = port_b_q.status;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Bench for writeback_port_arbiter: directed scenarios plus random traffic against a scan-list reference model.
// Latency: model expects grants combinationally and port contents one cycle later.
// Backpressure: random stall and a held-until-granted requester model.
module tb_writeback_port_arbiter;
  import wb_pkg::*;

  logic                           clock_i = 1'b0;
  logic                           reset_ni;
  logic [NUM_WB_LANES-1:0]        req_valid_i;
  logic [NUM_WB_LANES-1:0]        req_ready_o;
  logic [NUM_WB_LANES*ADDR_W-1:0] req_addr_i;
  logic [NUM_WB_LANES*DATA_W-1:0] req_data_i;
  logic [2*STATUS_W-1:0]          arith_status_i;
  logic                           stall_i;
  logic                           enableA_o, enableB_o;
  logic [ADDR_W-1:0]              AddressA_o, AddressB_o;
  logic [DATA_W-1:0]              DataA_o, DataB_o;
  logic [STATUS_W-1:0]            statusA_o, statusB_o;

  always #5 clock_i = ~clock_i;

  writeback_port_arbiter dut (
    .clock_i        (clock_i),
    .reset_ni       (reset_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .arith_status_i (arith_status_i),
    .stall_i        (stall_i),
    .enableA_o      (enableA_o),
    .enableB_o      (enableB_o),
    .AddressA_o     (AddressA_o),
    .AddressB_o     (AddressB_o),
    .DataA_o        (DataA_o),
    .DataB_o        (DataB_o),
    .statusA_o      (statusA_o),
    .statusB_o      (statusB_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: pointer, per-side status history, expected port registers.
  int                  m_ptr;
  logic [STATUS_W-1:0] m_last [2];
  logic                m_en   [2];
  logic [ADDR_W-1:0]   m_addr [2];
  logic [DATA_W-1:0]   m_data [2];
  logic [STATUS_W-1:0] m_st   [2];
  logic [3:0]          m_gnt;

  // Per-cycle model decision.
  int         p_ga, p_gb, p_np;
  logic [3:0] p_rdy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [ADDR_W-1:0] in_addr(input int l);
    return req_addr_i[l*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] in_data(input int l);
    return req_data_i[l*DATA_W +: DATA_W];
  endfunction

  // Status a lane would carry if granted now, given this cycle's winners.
  function automatic logic [STATUS_W-1:0] status_exp(input int l);
    case (l)
      0:       return arith_status_i[1:0];
      1:       return arith_status_i[3:2];
      2:       return (p_ga == 0 || p_gb == 0) ? arith_status_i[1:0] : m_last[0];
      default: return (p_ga == 1 || p_gb == 1) ? arith_status_i[3:2] : m_last[1];
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int p = 0; p < 2; p++) begin
      m_last[p] = '0; m_en[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0; m_st[p] = '0;
    end
    m_gnt = '0;
  endtask

  // Walk the lanes in priority order as a list: first valid to A, next different-address to B.
  task automatic model_arb();
    int skip;
    int l;
    skip  = -1;
    p_ga  = -1;
    p_gb  = -1;
    p_rdy = '0;
    p_np  = m_ptr;
    if (reset_ni && !stall_i) begin
      for (int k = 0; k < 4; k++) begin
        l = (m_ptr + k) % 4;
        if (req_valid_i[l]) begin
          if (p_ga < 0) p_ga = l;
          else if (p_gb < 0) begin
            if (in_addr(l) == in_addr(p_ga)) begin
              if (skip < 0) skip = l;
            end else p_gb = l;
          end
        end
      end
      if (p_ga >= 0) p_rdy[p_ga] = 1'b1;
      if (p_gb >= 0) p_rdy[p_gb] = 1'b1;
      if (skip >= 0)      p_np = skip;
      else if (p_gb >= 0) p_np = (p_gb + 1) % 4;
      else if (p_ga >= 0) p_np = (p_ga + 1) % 4;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic run_cycle();
    logic [STATUS_W-1:0] sa, sb;
    @(negedge clock_i);
    model_arb();
    check_val("ready",    32'(req_ready_o), 32'(p_rdy));
    check_val("enA",      32'(enableA_o),   32'(m_en[0]));
    check_val("enB",      32'(enableB_o),   32'(m_en[1]));
    check_val("addrA",    32'(AddressA_o),  32'(m_addr[0]));
    check_val("addrB",    32'(AddressB_o),  32'(m_addr[1]));
    check_val("dataA",    32'(DataA_o),     32'(m_data[0]));
    check_val("dataB",    32'(DataB_o),     32'(m_data[1]));
    check_val("statusA",  32'(statusA_o),   32'(m_st[0]));
    check_val("statusB",  32'(statusB_o),   32'(m_st[1]));
    sa = (p_ga >= 0) ? status_exp(p_ga) : '0;
    sb = (p_gb >= 0) ? status_exp(p_gb) : '0;
    @(posedge clock_i);
    m_gnt = '0;
    if (reset_ni) begin
      m_en[0] = (p_ga >= 0);
      m_en[1] = (p_gb >= 0);
      if (p_ga >= 0) begin m_addr[0] = in_addr(p_ga); m_data[0] = in_data(p_ga); m_st[0] = sa; end
      if (p_gb >= 0) begin m_addr[1] = in_addr(p_gb); m_data[1] = in_data(p_gb); m_st[1] = sb; end
      if (p_ga == 0 || p_gb == 0) m_last[0] = arith_status_i[1:0];
      if (p_ga == 1 || p_gb == 1) m_last[1] = arith_status_i[3:2];
      m_ptr = p_np;
      m_gnt = p_rdy;
    end
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input int a, input int d);
    req_valid_i[l]                 = v;
    req_addr_i[l*ADDR_W +: ADDR_W] = ADDR_W'(a);
    req_data_i[l*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic full_load();
    for (int l = 0; l < 4; l++) set_lane(l, 1'b1, l + 1, 16'hA0 + l);
  endtask

  task automatic random_lane(input int l);
    set_lane(l, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)));
  endtask

  initial begin
    model_reset();
    reset_ni       = 1'b0;
    stall_i        = 1'b0;
    req_valid_i    = 4'($urandom);
    req_addr_i     = 20'($urandom);
    req_data_i     = {$urandom, $urandom};
    arith_status_i = 4'($urandom);

    // Reset held with random inputs.
    repeat (3) run_cycle();

    // Full load from rr_ptr 0.
    full_load();
    arith_status_i = 4'b0000;
    reset_ni       = 1'b1;
    run_cycle();
    check_val("full_addrA1", 32'(AddressA_o), 32'd1);
    check_val("full_addrB1", 32'(AddressB_o), 32'd2);
    check_val("full_rdy2",   32'(req_ready_o), 32'b1100);
    run_cycle();
    check_val("full_addrA2", 32'(AddressA_o), 32'd3);
    check_val("full_addrB2", 32'(AddressB_o), 32'd4);
    check_val("full_dataB2", 32'(DataB_o),    32'hA3);

    // Same-address conflict at rr_ptr 0.
    set_lane(0, 1'b1, 5, 16'hC0);
    set_lane(1, 1'b1, 5, 16'hC1);
    set_lane(2, 1'b1, 6, 16'hC2);
    set_lane(3, 1'b0, 0, 0);
    #1;
    check_val("cf_rdy", 32'(req_ready_o), 32'b0101);
    run_cycle();
    check_val("cf_dataA", 32'(DataA_o),    32'hC0);
    check_val("cf_addrB", 32'(AddressB_o), 32'd6);
    req_valid_i = 4'b0010;
    #1;
    check_val("cf_rdy2", 32'(req_ready_o), 32'b0010);
    run_cycle();
    check_val("cf_dataA2", 32'(DataA_o),   32'hC1);
    check_val("cf_enB2",   32'(enableB_o), 32'd0);

    // Status inheritance and same-cycle forwarding.
    req_valid_i = '0;
    set_lane(0, 1'b1, 7, 16'hD0);
    arith_status_i = 4'b0010;
    run_cycle();
    check_val("st_arithA", 32'(statusA_o), 32'b10);
    req_valid_i = '0;
    set_lane(2, 1'b1, 10, 16'hD2);
    arith_status_i = 4'b0001;
    run_cycle();
    check_val("st_storeA", 32'(statusA_o), 32'b10);
    req_valid_i = '0;
    set_lane(0, 1'b1, 8, 16'hE0);
    set_lane(2, 1'b1, 9, 16'hE2);
    run_cycle();
    check_val("st_fwdA", 32'(statusA_o), 32'b01);
    check_val("st_fwdB", 32'(statusB_o), 32'b01);

    // Stall with full load, then resume at the same lanes (rr_ptr 3).
    full_load();
    stall_i = 1'b1;
    repeat (3) begin
      run_cycle();
      check_val("stall_enA", 32'(enableA_o),   32'd0);
      check_val("stall_rdy", 32'(req_ready_o), 32'd0);
    end
    stall_i = 1'b0;
    run_cycle();
    check_val("resume_addrA", 32'(AddressA_o), 32'd4);
    check_val("resume_addrB", 32'(AddressB_o), 32'd1);

    // Asynchronous reset dropped between edges during full load.
    run_cycle();
    @(negedge clock_i);
    reset_ni = 1'b0;
    #1;
    check_val("arst_enA",  32'(enableA_o),   32'd0);
    check_val("arst_enB",  32'(enableB_o),   32'd0);
    check_val("arst_addr", 32'(AddressA_o),  32'd0);
    check_val("arst_rdy",  32'(req_ready_o), 32'd0);
    model_reset();
    repeat (2) run_cycle();
    reset_ni = 1'b1;
    run_cycle();
    check_val("rel_addrA", 32'(AddressA_o), 32'd1);
    check_val("rel_addrB", 32'(AddressB_o), 32'd2);

    // Random traffic; a lane re-rolls only after a grant or while idle.
    for (int i = 0; i < 600; i++) begin
      stall_i        = ($urandom_range(0, 6) == 0);
      arith_status_i = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        if (m_gnt[l] || !req_valid_i[l]) random_lane(l);
      end
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
